rv_bus_arbiter: RTL and testbench
=================================

RV_BUS_ARBITER -- requirements
Module: rv_bus_arbiter

Interface
REQ-001 Parameter XLEN, default 32, address width.
REQ-002 Parameter NUM_MASTERS, default 2, legal 1..8, number of requesting masters (one per hart or DMA).
REQ-003 Parameter ARB_MODE, default 1; 0 = fixed priority (master 0 highest), 1 = round-robin.
REQ-004 Parameter TIMEOUT_CYCLES, default 256; 0 disables the timeout.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 m_req_valid  in  NUM_MASTERS  per-master request valid.
REQ-008 m_req_addr  in  NUM_MASTERS*XLEN  packed addresses, master i at [i*XLEN +: XLEN].
REQ-009 m_req_wdata  in  NUM_MASTERS*64  packed write data.
REQ-010 m_req_we  in  NUM_MASTERS  per-master write enable.
REQ-011 m_req_size  in  NUM_MASTERS*3  packed access size (existing bus size encoding).
REQ-012 m_req_ready  out  NUM_MASTERS  one-hot completion strobe.
REQ-013 m_req_rdata  out  64  read data, shared, valid only with m_req_ready.
REQ-014 m_req_err  out  1  completion was a timeout, valid only with m_req_ready.
REQ-015 s_req_valid, s_req_addr[XLEN], s_req_wdata[64], s_req_we, s_req_size[3]  out  single-master request to the bus interconnect.
REQ-016 s_req_ready  in  1  slave completion; s_req_rdata  in  64  read data.
REQ-017 grant_id  out  max(1,$clog2(NUM_MASTERS))  index of granted master; busy  out  1  high in BUSY.

Function
REQ-018 Protocol: master holds valid and all fields stable until the cycle its m_req_ready is 1; transfer completes in that cycle.
REQ-019 States IDLE and BUSY only.
REQ-020 IDLE: if any m_req_valid, select winner, register grant_id, go BUSY next cycle; s_req_valid is 0 in IDLE (one arbitration cycle per transfer).
REQ-021 Fixed priority: lowest-index requester wins.
REQ-022 Round-robin: search starts at rr_ptr, wraps NUM_MASTERS-1 to 0; on each completion (normal or timeout) rr_ptr <= grant_id+1 modulo NUM_MASTERS.
REQ-023 BUSY: s_req_* combinationally equal granted master's fields; s_req_valid = m_req_valid[grant_id].
REQ-024 BUSY with s_req_ready=1: m_req_ready[grant_id]=1 same cycle, m_req_rdata=s_req_rdata, m_req_err=0, go IDLE.
REQ-025 Timeout counter clears on entry to BUSY, increments each BUSY cycle without s_req_ready; width $clog2(TIMEOUT_CYCLES+1), no wrap.
REQ-026 When counter equals TIMEOUT_CYCLES-1 and s_req_ready=0: m_req_ready[grant_id]=1, m_req_err=1, m_req_rdata=0, s_req_valid=0 that cycle, go IDLE.
REQ-027 s_req_ready and timeout in same cycle: normal completion wins, m_req_err=0.
REQ-028 Granted master dropping valid in BUSY (protocol violation): s_req_valid=0, no m_req_ready, return to IDLE, rr_ptr unchanged.
REQ-029 Non-granted masters never see m_req_ready; their requests wait without limit.
REQ-030 s_req_ready ignored in IDLE.
REQ-031 NUM_MASTERS=1: arbitration degenerates, grant_id always 0, IDLE cycle still present.

Reset
REQ-032 On reset: state IDLE, rr_ptr 0, timeout counter 0, grant_id 0.
REQ-033 During reset: s_req_valid, m_req_ready, m_req_err, busy all 0; m_req_rdata 0.
REQ-034 Reset asserted mid-transfer abandons it without completion strobe; first arbitration follows the first cycle after reset deasserts.

Structure
REQ-035 Shared package rv_bus_pkg holds state encoding (IDLE=0, BUSY=1) and access-size constants.
REQ-036 One sub-module rv_rr_arbiter: combinational one-hot pick from request vector, start pointer and mode; state kept in rv_bus_arbiter.

Verification
REQ-037 Single master 0 read addr 0x8000_0010, slave ready after 2 cycles with rdata 0x1122334455667788 -> m_req_ready[0] pulses once with that rdata, err=0, total 4 cycles valid-to-ready.
REQ-038 ARB_MODE=1, masters 0 and 1 held valid continuously, slave always ready -> grants alternate 0,1,0,1 over 8 transfers.
REQ-039 ARB_MODE=0, same stimulus -> master 0 granted every transfer, master 1 never.
REQ-040 TIMEOUT_CYCLES=4, slave never ready -> m_req_ready[grant]=1 with err=1, rdata=0 on 4th BUSY cycle, then IDLE.
REQ-041 s_req_ready coincides with timeout cycle -> err=0, rdata from slave.
REQ-042 Reset pulsed during BUSY with master 1 granted -> no m_req_ready, outputs 0, rr_ptr 0, master 0 granted first after reset if both request.

Source files
------------

// File: rtl/rv_bus_pkg.sv
// Shared definitions for the RISC-V bus arbiter: FSM state encoding,
// bus access-size codes and pointer arithmetic helper.
package rv_bus_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bus_state_e;

    localparam logic [2:0] SIZE_BYTE  = 3'd0;
    localparam logic [2:0] SIZE_HALF  = 3'd1;
    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic [2:0] SIZE_DWORD = 3'd3;

    // Increment an index modulo n (n >= 1).
    function automatic int wrap_inc(input int idx, input int n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/rv_rr_arbiter.sv
// Combinational one-hot arbiter: picks the first requester starting at
// start_ptr (round-robin) or at index 0 (fixed priority).
module rv_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int GW          = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [GW-1:0]          start_ptr,
    input  logic                   rr_mode,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   any_req
);

    int base_s;
    int pos_s;

    // Rotating search; the inner loop keeps every bit-select constant.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        pos_s   = 0;
        if (rr_mode) begin
            base_s = int'(start_ptr);
        end else begin
            base_s = 0;
        end
        for (int off = 0; off < NUM_MASTERS; off++) begin
            if ((base_s + off) >= NUM_MASTERS) begin
                pos_s = base_s + off - NUM_MASTERS;
            end else begin
                pos_s = base_s + off;
            end
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (!any_req && req[j] && (j == pos_s)) begin
                    grant[j] = 1'b1;
                    any_req  = 1'b1;
                end else begin
                    grant[j] = grant[j];
                end
            end
        end
    end

endmodule

// File: rtl/rv_bus_arbiter.sv
// Multi-master to single-slave bus arbiter with fixed-priority or
// round-robin selection and a per-transfer completion timeout.
module rv_bus_arbiter
    import rv_bus_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_MASTERS    = 2,
    parameter int ARB_MODE       = 1,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_MASTERS-1:0]      m_req_valid,
    input  logic [NUM_MASTERS*XLEN-1:0] m_req_addr,
    input  logic [NUM_MASTERS*64-1:0]   m_req_wdata,
    input  logic [NUM_MASTERS-1:0]      m_req_we,
    input  logic [NUM_MASTERS*3-1:0]    m_req_size,
    output logic [NUM_MASTERS-1:0]      m_req_ready,
    output logic [63:0]                 m_req_rdata,
    output logic                        m_req_err,
    output logic                        s_req_valid,
    output logic [XLEN-1:0]             s_req_addr,
    output logic [63:0]                 s_req_wdata,
    output logic                        s_req_we,
    output logic [2:0]                  s_req_size,
    input  logic                        s_req_ready,
    input  logic [63:0]                 s_req_rdata,
    output logic [GW-1:0]               grant_id,
    output logic                        busy
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [TW-1:0] TMO_SAT  = {TW{1'b1}};
    localparam logic          RR_MODE  = (ARB_MODE != 0) ? 1'b1 : 1'b0;

    bus_state_e             state_r, state_nxt_s;
    logic [GW-1:0]          grant_r, grant_nxt_s;
    logic [GW-1:0]          rr_ptr_r, rr_ptr_nxt_s;
    logic [TW-1:0]          tmo_cnt_r, tmo_cnt_nxt_s;
    logic [NUM_MASTERS-1:0] arb_onehot_s;
    logic                   arb_any_s;
    logic [GW-1:0]          arb_idx_s;
    logic                   grant_valid_s;
    logic                   tmo_hit_s;
    logic                   in_busy_s;
    logic                   done_ok_s;
    logic                   done_tmo_s;

    rv_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .GW          (GW)
    ) u_arb (
        .req       (m_req_valid),
        .start_ptr (rr_ptr_r),
        .rr_mode   (RR_MODE),
        .grant     (arb_onehot_s),
        .any_req   (arb_any_s)
    );

    // One-hot winner to binary index.
    always_comb begin
        arb_idx_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (arb_onehot_s[i]) begin
                arb_idx_s = GW'(i);
            end else begin
                arb_idx_s = arb_idx_s;
            end
        end
    end

    assign grant_valid_s = m_req_valid[grant_r];
    assign tmo_hit_s     = (TIMEOUT_CYCLES != 0) && (tmo_cnt_r == TMO_LAST);
    assign in_busy_s     = (state_r == ST_BUSY) && !reset;

    // Next-state logic; a dropped request aborts silently without completion.
    always_comb begin
        state_nxt_s   = state_r;
        grant_nxt_s   = grant_r;
        rr_ptr_nxt_s  = rr_ptr_r;
        tmo_cnt_nxt_s = tmo_cnt_r;
        done_ok_s     = 1'b0;
        done_tmo_s    = 1'b0;
        if (reset) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arb_any_s) begin
                        state_nxt_s   = ST_BUSY;
                        grant_nxt_s   = arb_idx_s;
                        tmo_cnt_nxt_s = '0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (!grant_valid_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (s_req_ready) begin
                        done_ok_s    = 1'b1;
                        state_nxt_s  = ST_IDLE;
                        rr_ptr_nxt_s = GW'(wrap_inc(int'(grant_r), NUM_MASTERS));
                    end else if (tmo_hit_s) begin
                        done_tmo_s   = 1'b1;
                        state_nxt_s  = ST_IDLE;
                        rr_ptr_nxt_s = GW'(wrap_inc(int'(grant_r), NUM_MASTERS));
                    end else if (tmo_cnt_r != TMO_SAT) begin
                        tmo_cnt_nxt_s = tmo_cnt_r + TW'(1);
                    end else begin
                        tmo_cnt_nxt_s = tmo_cnt_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, grant, round-robin pointer and timeout counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            grant_r   <= '0;
            rr_ptr_r  <= '0;
            tmo_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            grant_r   <= grant_nxt_s;
            rr_ptr_r  <= rr_ptr_nxt_s;
            tmo_cnt_r <= tmo_cnt_nxt_s;
        end
    end

    // Completion strobe goes only to the granted master.
    always_comb begin
        m_req_ready = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_req_ready[i] = (done_ok_s || done_tmo_s) && (grant_r == GW'(i));
        end
    end

    assign m_req_rdata = done_ok_s ? s_req_rdata : 64'd0;
    assign m_req_err   = done_tmo_s;
    assign s_req_valid = in_busy_s && grant_valid_s && !(tmo_hit_s && !s_req_ready);
    assign s_req_addr  = m_req_addr[grant_r*XLEN +: XLEN];
    assign s_req_wdata = m_req_wdata[grant_r*64 +: 64];
    assign s_req_we    = m_req_we[grant_r];
    assign s_req_size  = m_req_size[grant_r*3 +: 3];
    assign grant_id    = grant_r;
    assign busy        = in_busy_s;

endmodule

// File: tb/tb_rv_bus_arbiter.sv
// Directed scoreboard bench for rv_bus_arbiter: one round-robin and one
// fixed-priority instance share stimulus; completions checked from a queue.
module tb_rv_bus_arbiter;

    localparam int XL = 32;
    localparam int NM = 2;

    typedef struct {
        logic [NM-1:0] ready;
        logic [63:0]   rdata;
        logic          err;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NM-1:0]    m_req_valid = '0;
    logic [NM*XL-1:0] m_req_addr = '0;
    logic [NM*64-1:0] m_req_wdata = '0;
    logic [NM-1:0]    m_req_we = '0;
    logic [NM*3-1:0]  m_req_size = '0;
    logic             s_req_ready = 1'b0;
    logic [63:0]      s_req_rdata = 64'd0;

    logic [NM-1:0] rr_ready, fp_ready;
    logic [63:0]   rr_rdata, fp_rdata, rr_s_wdata, fp_s_wdata;
    logic          rr_err, fp_err, rr_s_valid, fp_s_valid, rr_s_we, fp_s_we;
    logic [XL-1:0] rr_s_addr, fp_s_addr;
    logic [2:0]    rr_s_size, fp_s_size;
    logic          rr_grant, fp_grant, rr_busy, fp_busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;
    int   base;
    logic use_fp = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rv_bus_arbiter #(.XLEN(XL), .NUM_MASTERS(NM), .ARB_MODE(1), .TIMEOUT_CYCLES(4)) dut_rr (
        .clk(clk), .reset(reset), .m_req_valid(m_req_valid), .m_req_addr(m_req_addr),
        .m_req_wdata(m_req_wdata), .m_req_we(m_req_we), .m_req_size(m_req_size),
        .m_req_ready(rr_ready), .m_req_rdata(rr_rdata), .m_req_err(rr_err),
        .s_req_valid(rr_s_valid), .s_req_addr(rr_s_addr), .s_req_wdata(rr_s_wdata),
        .s_req_we(rr_s_we), .s_req_size(rr_s_size), .s_req_ready(s_req_ready),
        .s_req_rdata(s_req_rdata), .grant_id(rr_grant), .busy(rr_busy));

    rv_bus_arbiter #(.XLEN(XL), .NUM_MASTERS(NM), .ARB_MODE(0), .TIMEOUT_CYCLES(4)) dut_fp (
        .clk(clk), .reset(reset), .m_req_valid(m_req_valid), .m_req_addr(m_req_addr),
        .m_req_wdata(m_req_wdata), .m_req_we(m_req_we), .m_req_size(m_req_size),
        .m_req_ready(fp_ready), .m_req_rdata(fp_rdata), .m_req_err(fp_err),
        .s_req_valid(fp_s_valid), .s_req_addr(fp_s_addr), .s_req_wdata(fp_s_wdata),
        .s_req_we(fp_s_we), .s_req_size(fp_s_size), .s_req_ready(s_req_ready),
        .s_req_rdata(s_req_rdata), .grant_id(fp_grant), .busy(fp_busy));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push(input logic [NM-1:0] r, input logic [63:0] d, input logic e);
        exp_t x;
        x.ready = r;
        x.rdata = d;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    // Scoreboard: every completion strobe of the selected instance pops one entry.
    always @(negedge clk) begin
        exp_t e;
        logic [NM-1:0] rdy;
        rdy = use_fp ? fp_ready : rr_ready;
        if (rdy != '0) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_ready", 64'(rdy), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_ready", 64'(rdy), 64'(e.ready));
                chk("sb_rdata", use_fp ? fp_rdata : rr_rdata, e.rdata);
                chk("sb_err", 64'(use_fp ? fp_err : rr_err), 64'(e.err));
            end
        end
    end

    task automatic reset_dut();
        reset = 1'b1;
        m_req_valid = '0;
        s_req_ready = 1'b0;
        step();
        sample();
        chk("rst_busy", 64'(rr_busy), 64'd0);
        chk("rst_svalid", 64'(rr_s_valid), 64'd0);
        chk("rst_grant", 64'(rr_grant), 64'd0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        m_req_addr  = {32'h9000_0020, 32'h8000_0010};
        m_req_wdata = {64'hCAFE_F00D_1234_5678, 64'h0123_4567_89AB_CDEF};
        m_req_size  = {3'd2, 3'd3};

        // single master read, 4 cycles valid-to-ready
        reset_dut();
        m_req_valid = 2'b01;
        push(2'b01, 64'h1122_3344_5566_7788, 1'b0);
        sample();
        chk("a_idle_svalid", 64'(rr_s_valid), 64'd0);
        chk("a_idle_ready", 64'(rr_ready), 64'd0);
        step(); sample();
        chk("a_svalid", 64'(rr_s_valid), 64'd1);
        chk("a_addr", 64'(rr_s_addr), 64'h8000_0010);
        chk("a_size", 64'(rr_s_size), 64'd3);
        chk("a_we", 64'(rr_s_we), 64'd0);
        chk("a_busy", 64'(rr_busy), 64'd1);
        chk("a_ready_c2", 64'(rr_ready), 64'd0);
        step(); sample();
        chk("a_ready_c3", 64'(rr_ready), 64'd0);
        step();
        s_req_ready = 1'b1;
        s_req_rdata = 64'h1122_3344_5566_7788;
        sample();
        chk("a_ready_c4", 64'(rr_ready), 64'd1);
        step();
        m_req_valid = 2'b00;
        s_req_ready = 1'b0;
        sample();
        chk("a_idle_after", 64'(rr_busy), 64'd0);

        // round-robin alternation, slave always ready
        reset_dut();
        m_req_valid = 2'b11;
        s_req_ready = 1'b1;
        s_req_rdata = 64'hA5A5_0000_0000_0001;
        for (int k = 0; k < 8; k++) push((k % 2 == 0) ? 2'b01 : 2'b10, 64'hA5A5_0000_0000_0001, 1'b0);
        base = n_done;
        for (int c = 0; c < 40 && (n_done - base) < 8; c++) step();
        chk("b_count", 64'(n_done - base), 64'd8);
        m_req_valid = 2'b00;
        s_req_ready = 1'b0;
        sample();
        chk("b_idle", 64'(rr_busy), 64'd0);

        // fixed priority: master 0 every time
        use_fp = 1'b1;
        reset_dut();
        m_req_valid = 2'b11;
        s_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) push(2'b01, 64'hA5A5_0000_0000_0001, 1'b0);
        base = n_done;
        for (int c = 0; c < 40 && (n_done - base) < 8; c++) step();
        chk("c_count", 64'(n_done - base), 64'd8);
        m_req_valid = 2'b00;
        s_req_ready = 1'b0;
        sample();
        chk("c_idle", 64'(fp_busy), 64'd0);
        step();
        use_fp = 1'b0;

        // timeout on 4th busy cycle, master 1 write
        reset_dut();
        m_req_valid = 2'b10;
        m_req_we = 2'b10;
        s_req_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        push(2'b10, 64'd0, 1'b1);
        sample();
        for (int k = 1; k <= 3; k++) begin
            step(); sample();
            chk("d_ready_early", 64'(rr_ready), 64'd0);
            chk("d_svalid", 64'(rr_s_valid), 64'd1);
        end
        chk("d_wdata", rr_s_wdata, 64'hCAFE_F00D_1234_5678);
        chk("d_we", 64'(rr_s_we), 64'd1);
        step(); sample();
        chk("d_ready_tmo", 64'(rr_ready), 64'd2);
        chk("d_err", 64'(rr_err), 64'd1);
        chk("d_rdata", rr_rdata, 64'd0);
        chk("d_svalid_tmo", 64'(rr_s_valid), 64'd0);
        step();
        m_req_valid = 2'b00;
        m_req_we = 2'b00;
        sample();
        chk("d_idle", 64'(rr_busy), 64'd0);

        // slave ready coincides with timeout cycle: normal completion
        step();
        m_req_valid = 2'b01;
        push(2'b01, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
        sample();
        for (int k = 1; k <= 3; k++) begin
            step(); sample();
            chk("e_ready_early", 64'(rr_ready), 64'd0);
        end
        step();
        s_req_ready = 1'b1;
        s_req_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        sample();
        chk("e_err", 64'(rr_err), 64'd0);
        chk("e_rdata", rr_rdata, 64'hDEAD_BEEF_0BAD_F00D);
        step();
        m_req_valid = 2'b00;
        s_req_ready = 1'b0;
        sample();

        // granted master drops valid: abort, rr pointer kept at 1
        step();
        m_req_valid = 2'b10;
        sample();
        step(); sample();
        chk("g_grant", 64'(rr_grant), 64'd1);
        step();
        m_req_valid = 2'b00;
        sample();
        chk("g_svalid", 64'(rr_s_valid), 64'd0);
        step(); sample();
        chk("g_idle", 64'(rr_busy), 64'd0);
        step();
        m_req_valid = 2'b11;
        s_req_ready = 1'b1;
        s_req_rdata = 64'h0000_0000_0000_0042;
        push(2'b10, 64'h0000_0000_0000_0042, 1'b0);
        sample();
        step(); sample();
        chk("g_rr_kept", 64'(rr_grant), 64'd1);
        step();
        m_req_valid = 2'b00;
        s_req_ready = 1'b0;
        sample();

        // reset mid-transfer with master 1 granted
        reset_dut();
        m_req_valid = 2'b10;
        sample();
        step(); sample();
        chk("f_grant1", 64'(rr_grant), 64'd1);
        step();
        reset = 1'b1;
        s_req_ready = 1'b1;
        s_req_rdata = 64'h5555_AAAA_5555_AAAA;
        m_req_valid = 2'b11;
        sample();
        chk("f_rst_ready", 64'(rr_ready), 64'd0);
        chk("f_rst_svalid", 64'(rr_s_valid), 64'd0);
        chk("f_rst_busy", 64'(rr_busy), 64'd0);
        chk("f_rst_err", 64'(rr_err), 64'd0);
        chk("f_rst_rdata", rr_rdata, 64'd0);
        step();
        reset = 1'b0;
        sample();
        chk("f_post_busy", 64'(rr_busy), 64'd0);
        chk("f_post_grant", 64'(rr_grant), 64'd0);
        push(2'b01, 64'h5555_AAAA_5555_AAAA, 1'b0);
        step(); sample();
        chk("f_first_grant", 64'(rr_grant), 64'd0);
        step();
        m_req_valid = 2'b10;
        push(2'b10, 64'h5555_AAAA_5555_AAAA, 1'b0);
        sample();
        step(); sample();
        chk("f_next_grant", 64'(rr_grant), 64'd1);
        step();
        m_req_valid = 2'b00;
        s_req_ready = 1'b0;
        sample();
        step(); sample();

        chk("q_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
